// File: rtl/dmem_port_arbiter.sv
// Arbiter between the CPU MEM stage and the debug/loader port in front of the
// single-port 128-byte data memory. CPU has priority, with a burst limit so debug is never starved.
module dmem_port_arbiter #(
    parameter int ADDR_W        = 7,
    parameter int DATA_W        = 32,
    parameter int MAX_CPU_BURST = 4,
    localparam int CNT_W        = $clog2(MAX_CPU_BURST + 1)
) (
    input  logic              clk,
    input  logic              reset,
    // Request/grant handshake: a requester raises *_req with stable fields and
    // holds them until it sees *_gnt in the same cycle; the access is issued
    // in that cycle and the requester may present a new request next cycle.
    input  logic              i_cpu_req,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [3:0]        i_cpu_re,
    input  logic [3:0]        i_cpu_we,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_stall,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_dbg_req,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic              i_dbg_we,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic              o_dbg_gnt,
    output logic              o_dbg_rvalid,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_mem_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_fsm_state,
    output logic [CNT_W-1:0]  o_burst_cnt
);

    typedef enum logic {
        ST_CPU_PRI   = 1'b0,
        ST_DBG_FORCE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_CPU_BURST);

    state_t            r_state;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic              r_rd_pending;
    logic              r_rd_owner;
    logic [3:0]        r_rd_lanes;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_cpu_win;
    logic              w_dbg_win;
    logic              w_contend;
    logic [CNT_W-1:0]  w_burst_inc;
    logic              w_cpu_rd;
    logic              w_dbg_rd;
    logic              w_cpu_rvalid;
    logic              w_dbg_rvalid;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [3:0]        w_mem_we;
    logic [DATA_W-1:0] w_cpu_rdata_masked;

    // Grant selection: debug only overrides the CPU in its forced slot.
    always_comb begin
        w_cpu_win = 1'b0;
        w_dbg_win = 1'b0;
        if (!reset) begin
            if (r_state == ST_DBG_FORCE && i_dbg_req) begin
                w_dbg_win = 1'b1;
            end else if (i_cpu_req) begin
                w_cpu_win = 1'b1;
            end else if (i_dbg_req) begin
                w_dbg_win = 1'b1;
            end
        end
    end

    always_comb begin
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_mem_we    = 4'b0000;
        if (w_cpu_win) begin
            w_mem_addr  = i_cpu_addr;
            w_mem_wdata = i_cpu_wdata;
            w_mem_we    = i_cpu_we;
        end else if (w_dbg_win) begin
            w_mem_addr  = i_dbg_addr;
            w_mem_wdata = i_dbg_wdata;
            w_mem_we    = {4{i_dbg_we}};
        end
    end

    // A CPU slot with any write lane set is a write; read lanes are then ignored.
    assign w_cpu_rd    = w_cpu_win && (i_cpu_we == 4'b0000) && (i_cpu_re != 4'b0000);
    assign w_dbg_rd    = w_dbg_win && !i_dbg_we;
    assign w_contend   = w_cpu_win && i_dbg_req;
    assign w_burst_inc = (r_burst_cnt == BURST_MAX) ? r_burst_cnt : r_burst_cnt + 1'b1;

    always_comb begin
        w_cpu_rdata_masked = '0;
        for (int i = 0; i < 4; i++) begin
            w_cpu_rdata_masked[8*i +: 8] = r_rd_lanes[i] ? i_mem_rdata[8*i +: 8] : 8'h00;
        end
    end

    // Gating with reset drops a read response whose reset lands mid-flight.
    assign w_cpu_rvalid = r_rd_pending && !r_rd_owner && !reset;
    assign w_dbg_rvalid = r_rd_pending &&  r_rd_owner && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_CPU_PRI;
            r_burst_cnt  <= '0;
            r_rd_pending <= 1'b0;
            r_rd_owner   <= 1'b0;
            r_rd_lanes   <= 4'b0000;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                ST_CPU_PRI: begin
                    if (w_contend) begin
                        r_burst_cnt <= w_burst_inc;
                        if (w_burst_inc == BURST_MAX) begin
                            r_state <= ST_DBG_FORCE;
                        end
                    end else begin
                        r_burst_cnt <= '0;
                    end
                end
                ST_DBG_FORCE: begin
                    r_state     <= ST_CPU_PRI;
                    r_burst_cnt <= '0;
                end
                default: begin
                    r_state     <= ST_CPU_PRI;
                    r_burst_cnt <= '0;
                end
            endcase

            r_rd_pending <= w_cpu_rd || w_dbg_rd;
            if (w_cpu_win || w_dbg_win) begin
                r_rd_owner  <= w_dbg_win;
                r_rd_lanes  <= w_cpu_win ? i_cpu_re : 4'b1111;
                r_mem_addr  <= w_mem_addr;
                r_mem_wdata <= w_mem_wdata;
            end

            if (w_cpu_rvalid) begin
                r_cpu_rdata <= w_cpu_rdata_masked;
            end
            if (w_dbg_rvalid) begin
                r_dbg_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_cpu_gnt    = w_cpu_win;
    assign o_dbg_gnt    = w_dbg_win;
    assign o_cpu_stall  = i_cpu_req && !w_cpu_win;
    assign o_cpu_rvalid = w_cpu_rvalid;
    assign o_dbg_rvalid = w_dbg_rvalid;
    assign o_cpu_rdata  = w_cpu_rvalid ? w_cpu_rdata_masked : r_cpu_rdata;
    assign o_dbg_rdata  = w_dbg_rvalid ? i_mem_rdata : r_dbg_rdata;
    assign o_mem_en     = w_cpu_win || w_dbg_win;
    assign o_mem_addr   = w_mem_addr;
    assign o_mem_we     = w_mem_we;
    assign o_mem_wdata  = w_mem_wdata;
    assign o_fsm_state  = r_state;
    assign o_burst_cnt  = r_burst_cnt;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed cycles push expected control values and
// read responses into queues; a monitor process pops and compares them.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [6:0]  cpu_addr;
    logic [3:0]  cpu_re;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req;
    logic [6:0]  dbg_addr;
    logic        dbg_we;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_en;
    logic [6:0]  mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        fsm_state;
    logic [2:0]  burst_cnt;

    dmem_port_arbiter #(.ADDR_W(7), .DATA_W(32), .MAX_CPU_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .i_cpu_re(cpu_re),
        .i_cpu_we(cpu_we), .i_cpu_wdata(cpu_wdata),
        .o_cpu_gnt(cpu_gnt), .o_cpu_stall(cpu_stall),
        .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
        .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr), .i_dbg_we(dbg_we),
        .i_dbg_wdata(dbg_wdata),
        .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
        .o_mem_en(mem_en), .o_mem_addr(mem_addr), .o_mem_we(mem_we),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_fsm_state(fsm_state), .o_burst_cnt(burst_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed memory: writes commit at the edge, reads return next cycle.
    logic [7:0] mem [0:127] = '{default: 8'h00};
    initial mem_rdata = 32'h0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000)
                mem_rdata <= {mem[mem_addr + 7'd3], mem[mem_addr + 7'd2],
                              mem[mem_addr + 7'd1], mem[mem_addr]};
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) mem[mem_addr + 7'(i)] <= mem_wdata[8*i +: 8];
        end
    end

    // Scoreboard state
    typedef struct {
        logic        cg;
        logic        dg;
        logic        st;
        logic        en;
        logic [3:0]  we;
        logic [6:0]  addr;
        int          burst;
        int          fsm;
        logic        chk_rd;
        logic [31:0] crd;
        logic [31:0] drd;
    } ctl_t;

    ctl_t        ctl_q[$];
    logic [31:0] cpu_exp_q[$];
    logic [31:0] dbg_exp_q[$];
    ctl_t        nxt;
    logic        stim_done = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // Driver tasks
    task automatic set_cpu(input logic req, input logic [6:0] a, input logic [3:0] re,
                           input logic [3:0] we, input logic [31:0] wd);
        cpu_req = req; cpu_addr = a; cpu_re = re; cpu_we = we; cpu_wdata = wd;
    endtask

    task automatic set_dbg(input logic req, input logic [6:0] a, input logic we,
                           input logic [31:0] wd);
        dbg_req = req; dbg_addr = a; dbg_we = we; dbg_wdata = wd;
    endtask

    task automatic exp_ctl(input logic cg, input logic dg, input logic st, input logic en,
                           input logic [3:0] we, input logic [6:0] a, input int burst,
                           input int fsm);
        nxt.cg = cg; nxt.dg = dg; nxt.st = st; nxt.en = en; nxt.we = we; nxt.addr = a;
        nxt.burst = burst; nxt.fsm = fsm; nxt.chk_rd = 1'b0; nxt.crd = '0; nxt.drd = '0;
    endtask

    task automatic exp_rd(input logic [31:0] crd, input logic [31:0] drd);
        nxt.chk_rd = 1'b1; nxt.crd = crd; nxt.drd = drd;
    endtask

    task automatic step();
        ctl_q.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_cpu(1'b0, 7'h00, 4'h0, 4'h0, 32'h0);
        set_dbg(1'b0, 7'h00, 1'b0, 32'h0);
        exp_ctl(0, 0, 0, 0, 4'h0, 7'h00, -1, -1);
    endtask

    // Stimulus
    initial begin
        reset = 1'b1;
        set_cpu(1'b0, 7'h00, 4'h0, 4'h0, 32'h0);
        set_dbg(1'b0, 7'h00, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        idle(); exp_ctl(0, 0, 0, 0, 4'h0, 7'h00, 0, 0); exp_rd(32'h0, 32'h0); step();

        // CPU write then reads of full word and partial lanes, back to back
        set_cpu(1, 7'h10, 4'h0, 4'hF, 32'hDEADBEEF);
        exp_ctl(1, 0, 0, 1, 4'hF, 7'h10, 0, 0); step();
        set_cpu(1, 7'h10, 4'hF, 4'h0, 32'h0);
        exp_ctl(1, 0, 0, 1, 4'h0, 7'h10, 0, 0); cpu_exp_q.push_back(32'hDEADBEEF); step();
        set_cpu(1, 7'h10, 4'h1, 4'h0, 32'h0);
        exp_ctl(1, 0, 0, 1, 4'h0, 7'h10, 0, 0); cpu_exp_q.push_back(32'h000000EF); step();
        set_cpu(1, 7'h10, 4'h3, 4'h0, 32'h0);
        exp_ctl(1, 0, 0, 1, 4'h0, 7'h10, 0, 0); cpu_exp_q.push_back(32'h0000BEEF); step();
        idle(); step();

        // Debug preloads 0x20, then both contend: 4 CPU slots, one forced debug slot
        set_dbg(1, 7'h20, 1'b1, 32'hCAFEF00D);
        exp_ctl(0, 1, 0, 1, 4'hF, 7'h20, 0, 0); step();
        set_cpu(1, 7'h10, 4'hF, 4'h0, 32'h0);
        set_dbg(1, 7'h20, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_ctl(1, 0, 0, 1, 4'h0, 7'h10, i, 0);
            cpu_exp_q.push_back(32'hDEADBEEF);
            step();
        end
        exp_ctl(0, 1, 1, 1, 4'h0, 7'h20, 4, 1); dbg_exp_q.push_back(32'hCAFEF00D); step();
        set_dbg(0, 7'h00, 1'b0, 32'h0);
        exp_ctl(1, 0, 0, 1, 4'h0, 7'h10, 0, 0); cpu_exp_q.push_back(32'hDEADBEEF); step();
        idle(); step();
        idle(); exp_rd(32'hDEADBEEF, 32'hCAFEF00D); step();

        // Debug-only write then read of 0x00
        set_dbg(1, 7'h00, 1'b1, 32'h12345678);
        exp_ctl(0, 1, 0, 1, 4'hF, 7'h00, 0, 0); step();
        set_dbg(1, 7'h00, 1'b0, 32'h0);
        exp_ctl(0, 1, 0, 1, 4'h0, 7'h00, 0, 0); dbg_exp_q.push_back(32'h12345678); step();
        idle(); step();

        // Write wins over read: low lanes only, no response; then read back
        set_cpu(1, 7'h10, 4'hF, 4'h3, 32'h11112222);
        exp_ctl(1, 0, 0, 1, 4'h3, 7'h10, 0, 0); step();
        set_cpu(1, 7'h10, 4'hF, 4'h0, 32'h0);
        exp_ctl(1, 0, 0, 1, 4'h0, 7'h10, 0, 0); cpu_exp_q.push_back(32'hDEAD2222); step();
        // No-op slot
        set_cpu(1, 7'h44, 4'h0, 4'h0, 32'h0);
        exp_ctl(1, 0, 0, 1, 4'h0, 7'h44, 0, 0); step();

        // Reset lands the cycle after a CPU read grant: response is dropped
        set_cpu(1, 7'h10, 4'hF, 4'h0, 32'h0);
        exp_ctl(1, 0, 0, 1, 4'h0, 7'h10, 0, 0); step();
        reset = 1'b1;
        set_dbg(1, 7'h20, 1'b0, 32'h0);
        exp_ctl(0, 0, 1, 0, 4'h0, 7'h10, -1, -1); step();
        reset = 1'b0;
        exp_ctl(1, 0, 0, 1, 4'h0, 7'h10, 0, 0); exp_rd(32'h0, 32'h0);
        cpu_exp_q.push_back(32'hDEAD2222); step();
        idle(); step();
        idle(); step();
        stim_done = 1'b1;
    end

    // Comparison helper, used only by the monitor
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    initial begin
        int   cyc;
        ctl_t e;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ctl_q.size() > 0) begin
                e = ctl_q.pop_front();
                chk("cpu_gnt", 32'(cpu_gnt), 32'(e.cg));
                chk("dbg_gnt", 32'(dbg_gnt), 32'(e.dg));
                chk("cpu_stall", 32'(cpu_stall), 32'(e.st));
                chk("mem_en", 32'(mem_en), 32'(e.en));
                chk("mem_we", 32'(mem_we), 32'(e.we));
                if (e.en) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                if (e.burst >= 0) chk("burst_cnt", 32'(burst_cnt), 32'(e.burst));
                if (e.fsm >= 0) chk("fsm_state", 32'(fsm_state), 32'(e.fsm));
                if (e.chk_rd) begin
                    chk("cpu_rvalid_idle", 32'(cpu_rvalid), 32'h0);
                    chk("dbg_rvalid_idle", 32'(dbg_rvalid), 32'h0);
                    chk("cpu_rdata_hold", cpu_rdata, e.crd);
                    chk("dbg_rdata_hold", dbg_rdata, e.drd);
                end
            end
            if (cpu_rvalid) begin
                if (cpu_exp_q.size() == 0) chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'h0);
                else chk("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
            end
            if (dbg_rvalid) begin
                if (dbg_exp_q.size() == 0) chk("dbg_rvalid_unexpected", 32'(dbg_rvalid), 32'h0);
                else chk("dbg_rdata", dbg_rdata, dbg_exp_q.pop_front());
            end
            if ((stim_done && ctl_q.size() == 0) || cyc > 2000) begin
                chk("stim_complete", 32'(stim_done), 32'h1);
                chk("cpu_q_drain", 32'(cpu_exp_q.size()), 32'h0);
                chk("dbg_q_drain", 32'(dbg_exp_q.size()), 32'h0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

endmodule
